noc_client_endpoint: RTL and testbench



---
 rtl/noc_pkg.sv | 38 +++
 rtl/noc_lfsr16.sv | 27 ++
 rtl/noc_client_endpoint.sv | 165 ++++++++++++++++
 tb/tb_noc_client_endpoint.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the BFT NoC client endpoint.
//   tx_state_t     : transmit FSM states
//   LFSR_TAPS      : Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
//   PAT_*          : destination pattern encodings
//   flit field helpers: bit offsets derived from the address/payload widths
package noc_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_GAP,
    TX_SEND,
    TX_DONE
  } tx_state_t;

  // Right-shifting Galois form: bit 0 is fed back into bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int PAT_LFSR       = 0;
  localparam int PAT_COMPLEMENT = 1;

  // Flit layout: {valid_marker, dest[A_W], src[D_W/2], seq[D_W/2]}.
  function automatic int flit_w(input int a_w, input int d_w);
    return a_w + d_w + 1;
  endfunction

  function automatic int marker_bit(input int a_w, input int d_w);
    return a_w + d_w;
  endfunction

  function automatic int addr_lsb(input int d_w);
    return d_w;
  endfunction

  function automatic int src_lsb(input int d_w);
    return d_w / 2;
  endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Galois LFSR used for injection gaps, random destinations and the
// optional receive stall.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, loads seed
//   ce    : clock enable, state advances one step per enabled cycle
//   seed  : reset value (must be non-zero or the register locks up)
//   state : current LFSR value
module noc_lfsr16
  import noc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (ce) begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/noc_client_endpoint.sv
// PE-side endpoint of the BFT NoC. Injects rate-limited, addressed multi-flit
// packets on m_axis_c_* and sinks flits arriving on s_axis_c_*, counting both
// directions and flagging any received flit whose address is not this PE.
// Optional build macro: NOC_CLIENT_RX_STALL_EN adds pseudo-random receive
// backpressure (about 25% of cycles) driven by the LFSR.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   ce               : clock enable; when low every register holds
//   m_axis_c_*       : flit stream towards the network (wdata/wvalid/wlast out, wready in)
//   s_axis_c_*       : flit stream from the network (wdata/wvalid/wlast in, wready out)
//   done             : injection quota of LIMIT packets has been sent
//   sent_cnt         : flits accepted by the network (wraps at 2^32)
//   recv_cnt         : flits accepted from the network (wraps at 2^32)
//   err              : sticky, a flit addressed to another PE was received
module noc_client_endpoint
  import noc_pkg::*;
#(
  parameter int          N       = 2,
  parameter int          D_W     = 32,
  parameter int          A_W     = $clog2(N) + 1,
  parameter int          posx    = 0,
  parameter int          PAT     = 0,
  parameter int          RATE    = 100,
  parameter int          LIMIT   = 1024,
  parameter int          PKT_LEN = 4,
  parameter logic [31:0] SEED    = 32'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  output logic [A_W+D_W:0]     m_axis_c_wdata,
  output logic                 m_axis_c_wvalid,
  input  logic                 m_axis_c_wready,
  output logic                 m_axis_c_wlast,
  input  logic [A_W+D_W:0]     s_axis_c_wdata,
  input  logic                 s_axis_c_wvalid,
  output logic                 s_axis_c_wready,
  input  logic                 s_axis_c_wlast,
  output logic                 done,
  output logic [31:0]          sent_cnt,
  output logic [31:0]          recv_cnt,
  output logic                 err
);

  localparam int LOG2N     = $clog2(N);
  localparam int HALF      = D_W / 2;
  localparam int K_W       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int MARKER    = marker_bit(A_W, D_W);
  localparam int ADDR_LSB  = addr_lsb(D_W);
  localparam int SRC_LSB   = src_lsb(D_W);
  localparam logic [LOG2N-1:0] POS_L = LOG2N'(posx);
  localparam logic [A_W-1:0]   POS_A = A_W'(posx);

  tx_state_t        state_q, state_d;
  logic [15:0]      lfsr;
  logic [A_W-1:0]   dest_q, dest_d, next_dest;
  logic [LOG2N-1:0] rnd_dest;
  logic [K_W-1:0]   flit_q, flit_d;
  logic [31:0]      pkt_q, pkt_d;
  logic             rx_en_q;
  logic             gap_pass, last_flit, tx_hs, rx_hs;
  logic             sink_unused;

  noc_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .seed  (SEED[15:0] ^ 16'(posx)),
    .state (lfsr)
  );

  // RATE >= 100 must always pass even though LFSR[6:0] reaches 127.
  assign gap_pass  = (RATE >= 100) || ({25'd0, lfsr[6:0]} < 32'(RATE));
  assign last_flit = (flit_q == K_W'(PKT_LEN - 1));
  assign tx_hs     = ce && (state_q == TX_SEND) && m_axis_c_wready;
  assign rx_hs     = ce && s_axis_c_wvalid && s_axis_c_wready;
  assign done      = (state_q == TX_DONE);

  // Random destinations never target this PE: a self hit is flipped to the neighbour.
  always_comb begin
    rnd_dest = lfsr[LOG2N-1:0];
    if (rnd_dest == POS_L) rnd_dest = POS_L ^ LOG2N'(1);
    if (PAT == PAT_COMPLEMENT) next_dest = A_W'(POS_L ^ LOG2N'(N - 1));
    else                       next_dest = A_W'(rnd_dest);
  end

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    flit_d  = flit_q;
    pkt_d   = pkt_q;
    case (state_q)
      TX_IDLE: state_d = (LIMIT == 0) ? TX_DONE : TX_GAP;
      TX_GAP: begin
        if (gap_pass) begin
          state_d = TX_SEND;
          dest_d  = next_dest;
          flit_d  = '0;
        end
      end
      TX_SEND: begin
        if (m_axis_c_wready) begin
          if (last_flit) begin
            pkt_d   = pkt_q + 32'd1;
            flit_d  = '0;
            state_d = (pkt_d == 32'(LIMIT)) ? TX_DONE : TX_GAP;
          end else begin
            flit_d = flit_q + K_W'(1);
          end
        end
      end
      default: state_d = TX_DONE;
    endcase
  end

  // Flit contents come only from registers, so they are stable while a
  // presented flit waits for wready.
  always_comb begin
    m_axis_c_wvalid = (state_q == TX_SEND);
    m_axis_c_wlast  = m_axis_c_wvalid && last_flit;
    m_axis_c_wdata  = '0;
    if (m_axis_c_wvalid) begin
      m_axis_c_wdata[MARKER]             = 1'b1;
      m_axis_c_wdata[ADDR_LSB +: A_W]    = dest_q;
      m_axis_c_wdata[SRC_LSB +: HALF]    = HALF'(posx);
      m_axis_c_wdata[0 +: HALF]          = HALF'(sent_cnt);
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      dest_q   <= '0;
      flit_q   <= '0;
      pkt_q    <= '0;
      sent_cnt <= '0;
      recv_cnt <= '0;
      err      <= 1'b0;
      rx_en_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      dest_q  <= dest_d;
      flit_q  <= flit_d;
      pkt_q   <= pkt_d;
      rx_en_q <= 1'b1;
      if (tx_hs) sent_cnt <= sent_cnt + 32'd1;
      if (rx_hs) begin
        recv_cnt <= recv_cnt + 32'd1;
        if (s_axis_c_wdata[ADDR_LSB +: A_W] != POS_A) err <= 1'b1;
      end
    end
  end

`ifdef NOC_CLIENT_RX_STALL_EN
  assign s_axis_c_wready = rx_en_q && (lfsr[9:8] != 2'b11);
`else
  assign s_axis_c_wready = rx_en_q;
`endif

  // Only the address field of received flits and a few LFSR bits are used.
  assign sink_unused = ^{lfsr, s_axis_c_wdata, s_axis_c_wlast};

endmodule

// File: tb/tb_noc_client_endpoint.sv
// Self-checking bench for noc_client_endpoint. Two instances:
//   dut_a : N=4, posx=1, bit-complement pattern, RATE=100, LIMIT=2, PKT_LEN=4
//   dut_r : N=2, posx=0, LFSR pattern, RATE=50, LIMIT=16, PKT_LEN=2
// Expected flits are queued before each run and popped by negedge monitors.
module tb_noc_client_endpoint;

  localparam int D_W  = 32;
  localparam int AW_A = 3;
  localparam int AW_R = 2;
  localparam int FW_A = AW_A + D_W + 1;
  localparam int FW_R = AW_R + D_W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- dut_a ----------------
  logic            rst_a, ce_a, m_wvalid_a, m_wready_a, m_wlast_a;
  logic [FW_A-1:0] m_wdata_a, s_wdata_a;
  logic            s_wvalid_a, s_wready_a, s_wlast_a, done_a, err_a;
  logic [31:0]     sent_a, recv_a;

  noc_client_endpoint #(
    .N(4), .D_W(D_W), .posx(1), .PAT(1), .RATE(100), .LIMIT(2), .PKT_LEN(4)
  ) dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a),
    .m_axis_c_wdata(m_wdata_a), .m_axis_c_wvalid(m_wvalid_a),
    .m_axis_c_wready(m_wready_a), .m_axis_c_wlast(m_wlast_a),
    .s_axis_c_wdata(s_wdata_a), .s_axis_c_wvalid(s_wvalid_a),
    .s_axis_c_wready(s_wready_a), .s_axis_c_wlast(s_wlast_a),
    .done(done_a), .sent_cnt(sent_a), .recv_cnt(recv_a), .err(err_a)
  );

  // ---------------- dut_r ----------------
  logic            rst_r, ce_r, m_wvalid_r, m_wready_r, m_wlast_r;
  logic [FW_R-1:0] m_wdata_r, s_wdata_r;
  logic            s_wvalid_r, s_wready_r, s_wlast_r, done_r, err_r;
  logic [31:0]     sent_r, recv_r;

  noc_client_endpoint #(
    .N(2), .D_W(D_W), .posx(0), .PAT(0), .RATE(50), .LIMIT(16), .PKT_LEN(2)
  ) dut_r (
    .clk(clk), .rst(rst_r), .ce(ce_r),
    .m_axis_c_wdata(m_wdata_r), .m_axis_c_wvalid(m_wvalid_r),
    .m_axis_c_wready(m_wready_r), .m_axis_c_wlast(m_wlast_r),
    .s_axis_c_wdata(s_wdata_r), .s_axis_c_wvalid(s_wvalid_r),
    .s_axis_c_wready(s_wready_r), .s_axis_c_wlast(s_wlast_r),
    .done(done_r), .sent_cnt(sent_r), .recv_cnt(recv_r), .err(err_r)
  );

  // Expected {wlast, wdata}: marker, dest, src=posx, seq=flit number.
  function automatic logic [FW_A:0] exp_a(input int j);
    logic [15:0] seq;
    seq = 16'(j);
    return {(j % 4 == 3), 1'b1, 3'd2, 16'd1, seq};
  endfunction

  function automatic logic [FW_R:0] exp_r(input int j);
    logic [15:0] seq;
    seq = 16'(j);
    return {(j % 2 == 1), 1'b1, 2'd1, 16'd0, seq};
  endfunction

  // ---------------- monitors ----------------
  logic [FW_A:0] q_a[$];
  int            hs_a, cyc_a, done_cyc_a;
  int            hs_cyc_a[8];
  logic          pend_a;
  logic [FW_A:0] prev_a;

  always @(negedge clk) begin
    if (rst_a) begin
      cyc_a = 0; hs_a = 0; pend_a = 1'b0; done_cyc_a = -1;
    end else begin
      cyc_a++;
      if (pend_a) check("a_stall_hold", {m_wvalid_a, m_wlast_a, m_wdata_a}, {1'b1, prev_a});
      if (done_a && done_cyc_a < 0) done_cyc_a = cyc_a;
      if (m_wvalid_a && m_wready_a && ce_a) begin
        check("a_flit_expected", 64'(q_a.size() != 0), 1);
        if (q_a.size() != 0) check("a_flit", {m_wlast_a, m_wdata_a}, q_a.pop_front());
        if (hs_a < 8) hs_cyc_a[hs_a] = cyc_a;
        hs_a++;
      end
      pend_a = m_wvalid_a && !(m_wready_a && ce_a);
      prev_a = {m_wlast_a, m_wdata_a};
    end
  end

  logic [FW_R:0] q_r[$];
  int            hs_r, cyc_r;
  int            hs_cyc_r[32];
  int            ref_cyc_r[32];
  logic          pend_r;
  logic [FW_R:0] prev_r;

  always @(negedge clk) begin
    if (rst_r) begin
      cyc_r = 0; hs_r = 0; pend_r = 1'b0;
    end else begin
      cyc_r++;
      if (pend_r) check("r_stall_hold", {m_wvalid_r, m_wlast_r, m_wdata_r}, {1'b1, prev_r});
      if (m_wvalid_r && m_wready_r && ce_r) begin
        check("r_flit_expected", 64'(q_r.size() != 0), 1);
        if (q_r.size() != 0) check("r_flit", {m_wlast_r, m_wdata_r}, q_r.pop_front());
        if (hs_r < 32) hs_cyc_r[hs_r] = cyc_r;
        hs_r++;
      end
      pend_r = m_wvalid_r && !(m_wready_r && ce_r);
      prev_r = {m_wlast_r, m_wdata_r};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_a();
    rst_a = 1'b1; ce_a = 1'b1; m_wready_a = 1'b1;
    s_wvalid_a = 1'b0; s_wlast_a = 1'b0; s_wdata_a = '0;
    repeat (2) @(posedge clk);
    #1;
    q_a.delete();
    for (int j = 0; j < 8; j++) q_a.push_back(exp_a(j));
  endtask

  task automatic reset_r();
    rst_r = 1'b1; ce_r = 1'b1; m_wready_r = 1'b1;
    s_wvalid_r = 1'b0; s_wlast_r = 1'b0; s_wdata_r = '0;
    repeat (2) @(posedge clk);
    #1;
    q_r.delete();
    for (int j = 0; j < 32; j++) q_r.push_back(exp_r(j));
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin @(posedge clk); #1; n++; end
    check("a_done_reached", 64'(done_a), 1);
  endtask

  task automatic wait_done_r(input int budget);
    int n = 0;
    while (!done_r && n < budget) begin @(posedge clk); #1; n++; end
    check("r_done_reached", 64'(done_r), 1);
  endtask

  task automatic wait_hs_a(input int target);
    int n = 0;
    while (hs_a < target && n < 100) begin @(posedge clk); #1; n++; end
    check("a_hs_reached", 64'(hs_a), 64'(target));
  endtask

  task automatic wait_hs_r(input int target);
    int n = 0;
    while (hs_r < target && n < 500) begin @(posedge clk); #1; n++; end
    check("r_hs_reached", 64'(hs_r), 64'(target));
  endtask

  task automatic rx_send_a(input logic [AW_A-1:0] addr);
    int n = 0;
    s_wdata_a = {1'b1, addr, 32'h1234_5678}; s_wvalid_a = 1'b1; s_wlast_a = 1'b1;
    @(negedge clk);
    while (!s_wready_a && n < 50) begin @(negedge clk); n++; end
    check("a_rx_ready", 64'(s_wready_a), 1);
    @(posedge clk); #1;
    s_wvalid_a = 1'b0; s_wlast_a = 1'b0;
  endtask

  task automatic rx_send_r(input logic [AW_R-1:0] addr);
    int n = 0;
    s_wdata_r = {1'b1, addr, 32'hCAFE_0001}; s_wvalid_r = 1'b1; s_wlast_r = 1'b1;
    @(negedge clk);
    while (!s_wready_r && n < 50) begin @(negedge clk); n++; end
    check("r_rx_ready", 64'(s_wready_r), 1);
    @(posedge clk); #1;
    s_wvalid_r = 1'b0; s_wlast_r = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_r = 1'b1; ce_r = 1'b1; m_wready_r = 1'b1;
    s_wvalid_r = 1'b0; s_wlast_r = 1'b0; s_wdata_r = '0;

    // Reset state, then an unstalled two-packet run.
    reset_a();
    check("a_rst_wvalid", 64'(m_wvalid_a), 0);
    check("a_rst_wlast",  64'(m_wlast_a), 0);
    check("a_rst_wdata",  64'(m_wdata_a), 0);
    check("a_rst_sready", 64'(s_wready_a), 0);
    check("a_rst_done",   64'(done_a), 0);
    check("a_rst_sent",   64'(sent_a), 0);
    check("a_rst_recv",   64'(recv_a), 0);
    check("a_rst_err",    64'(err_a), 0);
    rst_a = 1'b0;
    @(posedge clk); #1;
`ifndef NOC_CLIENT_RX_STALL_EN
    check("a_sready_after_rst", 64'(s_wready_a), 1);
`endif
    wait_done_a(200);
    @(posedge clk); #1;
    check("a_sent_total", 64'(sent_a), 8);
    check("a_flits_seen", 64'(hs_a), 8);
    check("a_queue_empty", 64'(q_a.size()), 0);
    check("a_done_latency", 64'(done_cyc_a - hs_cyc_a[7]), 1);
    // One GAP cycle between packets, no bubbles inside a packet.
    for (int j = 1; j < 8; j++)
      check("a_flit_spacing", 64'(hs_cyc_a[j] - hs_cyc_a[j-1]), (j % 4 == 0) ? 2 : 1);

    // Backpressure: wready low for 5 cycles mid-packet.
    reset_a();
    rst_a = 1'b0;
    wait_hs_a(2);
    m_wready_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("a_stall_sent", 64'(sent_a), 2);
    m_wready_a = 1'b1;
    wait_done_a(200);
    check("a_stall_sent_total", 64'(sent_a), 8);
    check("a_stall_queue_empty", 64'(q_a.size()), 0);

    // Reset during flit 2 of packet 0, then a full run with concurrent RX.
    reset_a();
    rst_a = 1'b0;
    wait_hs_a(2);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("a_midrst_wvalid", 64'(m_wvalid_a), 0);
    check("a_midrst_wlast",  64'(m_wlast_a), 0);
    check("a_midrst_sent",   64'(sent_a), 0);
    q_a.delete();
    for (int j = 0; j < 8; j++) q_a.push_back(exp_a(j));
    rst_a = 1'b0;
    fork
      wait_done_a(300);
      begin
        rx_send_a(3'd1);
        check("a_rx_recv1", 64'(recv_a), 1);
        check("a_rx_err1",  64'(err_a), 0);
        rx_send_a(3'd3);
        check("a_rx_recv2", 64'(recv_a), 2);
        check("a_rx_err2",  64'(err_a), 1);
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("a_err_sticky",     64'(err_a), 1);
    check("a_recv_final",     64'(recv_a), 2);
    check("a_midrst_sent_total", 64'(sent_a), 8);
    check("a_midrst_queue_empty", 64'(q_a.size()), 0);

    // LFSR destinations with self-exclusion; record timing as a reference.
    reset_r();
    check("r_rst_wvalid", 64'(m_wvalid_r), 0);
    check("r_rst_sent",   64'(sent_r), 0);
    rst_r = 1'b0;
    fork
      wait_done_r(2000);
      rx_send_r(2'd0);
    join
    check("r_sent_total", 64'(sent_r), 32);
    check("r_recv_total", 64'(recv_r), 1);
    check("r_err_clear",  64'(err_r), 0);
    check("r_queue_empty", 64'(q_r.size()), 0);
    for (int j = 0; j < 32; j++) ref_cyc_r[j] = hs_cyc_r[j];

    // Clock-enable low for 6 cycles inside a packet: same run shifted by 6.
    reset_r();
    rst_r = 1'b0;
    wait_hs_r(3);
    ce_r = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("r_ce_sent_hold", 64'(sent_r), 3);
    check("r_ce_wvalid_hold", 64'(m_wvalid_r), 1);
    ce_r = 1'b1;
    wait_done_r(2000);
    check("r_ce_sent_total", 64'(sent_r), 32);
    check("r_ce_queue_empty", 64'(q_r.size()), 0);
    for (int j = 0; j < 32; j++)
      check("r_ce_shift", 64'(hs_cyc_r[j]), 64'(ref_cyc_r[j] + ((j >= 3) ? 6 : 0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
